mac_learn_table: RTL and testbench

- Parametrised learning MAC table for the output-port-lookup stage of the learning switch.
- Maps a destination MAC to an output-queue bitmap and learns source MAC/port pairs.
- Adds two things the previous generation lacked: a register-based parallel-compare CAM (no external CAM core, any depth) and per-entry hardware aging with valid bits.
- Sits between the header parser and the output-port-lookup control FSM; host access is through the register interface.

---
 rtl/mac_learn_pkg.sv | 20 ++
 rtl/lowest_set_encoder.sv | 25 ++
 rtl/mac_learn_table.sv | 258 +++++++++++++++++++++++++
 tb/tb_mac_learn_table.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_learn_pkg.sv
// Shared definitions for the learning MAC table.
//   state_e   : control FSM states.
//   MacW      : width of an Ethernet MAC address.
//   BcastMac  : key of the broadcast entry loaded into the last slot after INIT.
//   BcastProt : protect bit of the broadcast entry (it never ages or relearns).
package mac_learn_pkg;

  localparam int unsigned MacW = 48;
  localparam logic [MacW-1:0] BcastMac = '1;
  localparam logic BcastProt = 1'b1;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StDstCmp,
    StSrcCmp,
    StLearn
  } state_e;

endpackage

// File: rtl/lowest_set_encoder.sv
// Priority encoder: reports the index of the lowest set bit of vec_i.
//   vec_i   : request vector.
//   idx_o   : index of the lowest set bit (0 when none is set).
//   found_o : at least one bit of vec_i is set.
module lowest_set_encoder #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (vec_i[i] && !found_o) begin
        idx_o   = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_learn_table.sv
// Learning MAC table for the output-port-lookup stage.
// A register-based CAM maps a destination MAC to an output-queue bitmap and
// learns source MAC / ingress-port pairs. Entries carry valid/protect bits and
// an age counter driven by an external tick.
//   clk, reset            : clock, synchronous active-high reset.
//   dst_mac_i, src_mac_i  : lookup and learn keys, src_port_i ingress index.
//   lookup_req_i/_ack_o   : four-phase handshake, dst_ports_o valid while ack.
//   age_enable_i/tick_i   : aging control.
//   rd_*                  : host read port (registered data, rd_ack_o pulse).
//   wr_*                  : host write port (accepted in IDLE, wr_ack_o pulse).
//   lut_hit_o/lut_miss_o  : destination lookup result pulses.
//   learn_full_o          : new source could not be stored.
//   entry_aged_o          : at least one entry expired on a tick.
module mac_learn_table
  import mac_learn_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT_QUEUES = 8,
  parameter int unsigned NUM_IQ_BITS       = 3,
  parameter int unsigned LUT_DEPTH_BITS    = 5,
  parameter int unsigned AGE_BITS          = 4,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MacW-1:0]              dst_mac_i,
  input  logic [MacW-1:0]              src_mac_i,
  input  logic [NUM_IQ_BITS-1:0]       src_port_i,
  input  logic                         lookup_req_i,
  output logic [NUM_OUTPUT_QUEUES-1:0] dst_ports_o,
  output logic                         lookup_ack_o,
  input  logic                         age_enable_i,
  input  logic                         age_tick_i,
  input  logic [LUT_DEPTH_BITS-1:0]    rd_addr_i,
  input  logic                         rd_req_i,
  output logic [MacW-1:0]              rd_mac_o,
  output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq_o,
  output logic                         rd_wr_protect_o,
  output logic                         rd_valid_o,
  output logic [AGE_BITS-1:0]          rd_age_o,
  output logic                         rd_ack_o,
  input  logic [LUT_DEPTH_BITS-1:0]    wr_addr_i,
  input  logic                         wr_req_i,
  input  logic [MacW-1:0]              wr_mac_i,
  input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq_i,
  input  logic                         wr_protect_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ack_o,
  output logic                         lut_hit_o,
  output logic                         lut_miss_o,
  output logic                         learn_full_o,
  output logic                         entry_aged_o
);

  localparam int unsigned LUT_DEPTH = 1 << LUT_DEPTH_BITS;
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  // Table storage
  logic [LUT_DEPTH-1:0]         valid_q;
  logic [LUT_DEPTH-1:0]         prot_q;
  logic [NUM_OUTPUT_QUEUES-1:0] oq_q  [LUT_DEPTH];
  logic [MacW-1:0]              mac_q [LUT_DEPTH];
  logic [AGE_BITS-1:0]          age_q [LUT_DEPTH];

  state_e                       state_q;
  logic [LUT_DEPTH_BITS-1:0]    init_idx_q;
  logic [MacW-1:0]              dst_mac_q, src_mac_q;
  logic [NUM_OUTPUT_QUEUES-1:0] src_dec_q, src_dec_d;
  logic                         src_hit_q, free_found_q;
  logic [LUT_DEPTH_BITS-1:0]    src_idx_q, free_idx_q;

  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports_q;
  logic                         lookup_ack_q, lut_hit_q, lut_miss_q;
  logic                         learn_full_q, entry_aged_q, wr_ack_q, rd_ack_q;
  logic [MacW-1:0]              rd_mac_q;
  logic [NUM_OUTPUT_QUEUES-1:0] rd_oq_q;
  logic                         rd_prot_q, rd_valid_q;
  logic [AGE_BITS-1:0]          rd_age_q;

  // Shared parallel compare: DST_CMP uses the destination key, otherwise the source key.
  logic [MacW-1:0]           cmp_key;
  logic [LUT_DEPTH-1:0]      match_vec;
  logic [LUT_DEPTH_BITS-1:0] match_idx, free_idx;
  logic                      match_found, free_found;

  always_comb begin
    cmp_key = (state_q == StDstCmp) ? dst_mac_q : src_mac_q;
    for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (mac_q[i] == cmp_key);
    end
  end

  assign src_dec_d = {{(NUM_OUTPUT_QUEUES-1){1'b0}}, 1'b1} << src_port_i;

  lowest_set_encoder #(
    .WIDTH(LUT_DEPTH)
  ) u_match_enc (
    .vec_i  (match_vec),
    .idx_o  (match_idx),
    .found_o(match_found)
  );

  lowest_set_encoder #(
    .WIDTH(LUT_DEPTH)
  ) u_free_enc (
    .vec_i  (~valid_q),
    .idx_o  (free_idx),
    .found_o(free_found)
  );

  // Statement order inside the clocked block sets the per-entry precedence:
  // aging first, then learn, then host write (later non-blocking writes win).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      init_idx_q   <= '0;
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      src_dec_q    <= '0;
      src_hit_q    <= 1'b0;
      src_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      dst_ports_q  <= '0;
      lookup_ack_q <= 1'b0;
      lut_hit_q    <= 1'b0;
      lut_miss_q   <= 1'b0;
      learn_full_q <= 1'b0;
      entry_aged_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_mac_q     <= '0;
      rd_oq_q      <= '0;
      rd_prot_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_age_q     <= '0;
    end else begin
      lut_hit_q    <= 1'b0;
      lut_miss_q   <= 1'b0;
      learn_full_q <= 1'b0;
      entry_aged_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;

      if (lookup_ack_q && !lookup_req_i) begin
        lookup_ack_q <= 1'b0;
      end

      if (state_q != StInit) begin
        // Reads sample the pre-update table.
        if (rd_req_i) begin
          rd_mac_q   <= mac_q[rd_addr_i];
          rd_oq_q    <= oq_q[rd_addr_i];
          rd_prot_q  <= prot_q[rd_addr_i];
          rd_valid_q <= valid_q[rd_addr_i];
          rd_age_q   <= age_q[rd_addr_i];
          rd_ack_q   <= 1'b1;
        end
        if (age_tick_i && age_enable_i) begin
          for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
            if (valid_q[i] && !prot_q[i]) begin
              if (age_q[i] == AGE_MAX) begin
                valid_q[i]   <= 1'b0;
                entry_aged_q <= 1'b1;
              end else begin
                age_q[i] <= age_q[i] + 1'b1;
              end
            end
          end
        end
      end

      unique case (state_q)
        StInit: begin
          valid_q[init_idx_q] <= 1'b0;
          prot_q[init_idx_q]  <= 1'b0;
          oq_q[init_idx_q]    <= '0;
          mac_q[init_idx_q]   <= '0;
          age_q[init_idx_q]   <= '0;
          init_idx_q          <= init_idx_q + 1'b1;
          // The last slot holds the permanent broadcast entry.
          if (&init_idx_q) begin
            valid_q[init_idx_q] <= 1'b1;
            prot_q[init_idx_q]  <= BcastProt;
            oq_q[init_idx_q]    <= DEFAULT_MISS_OUTPUT_PORTS;
            mac_q[init_idx_q]   <= BcastMac;
            state_q             <= StIdle;
          end
        end
        StIdle: begin
          if (wr_req_i) begin
            valid_q[wr_addr_i] <= wr_valid_i;
            prot_q[wr_addr_i]  <= wr_protect_i;
            oq_q[wr_addr_i]    <= wr_oq_i;
            mac_q[wr_addr_i]   <= wr_mac_i;
            age_q[wr_addr_i]   <= '0;
            wr_ack_q           <= 1'b1;
          end else if (lookup_req_i && !lookup_ack_q) begin
            dst_mac_q <= dst_mac_i;
            src_mac_q <= src_mac_i;
            src_dec_q <= src_dec_d;
            state_q   <= StDstCmp;
          end
        end
        StDstCmp: begin
          dst_ports_q  <= (match_found ? oq_q[match_idx] : DEFAULT_MISS_OUTPUT_PORTS)
                          & ~src_dec_q;
          lookup_ack_q <= 1'b1;
          lut_hit_q    <= match_found;
          lut_miss_q   <= !match_found;
          state_q      <= StSrcCmp;
        end
        StSrcCmp: begin
          // Free slot is taken from the pre-tick table so an entry expiring
          // now cannot be reused by this lookup's learn.
          src_hit_q    <= match_found;
          src_idx_q    <= match_idx;
          free_found_q <= free_found;
          free_idx_q   <= free_idx;
          state_q      <= StLearn;
        end
        StLearn: begin
          if (src_hit_q) begin
            if (!prot_q[src_idx_q]) begin
              valid_q[src_idx_q] <= 1'b1;
              oq_q[src_idx_q]    <= src_dec_q;
              age_q[src_idx_q]   <= '0;
            end
          end else if (free_found_q) begin
            valid_q[free_idx_q] <= 1'b1;
            prot_q[free_idx_q]  <= 1'b0;
            oq_q[free_idx_q]    <= src_dec_q;
            mac_q[free_idx_q]   <= src_mac_q;
            age_q[free_idx_q]   <= '0;
          end else begin
            learn_full_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign dst_ports_o     = dst_ports_q;
  assign lookup_ack_o    = lookup_ack_q;
  assign lut_hit_o       = lut_hit_q;
  assign lut_miss_o      = lut_miss_q;
  assign learn_full_o    = learn_full_q;
  assign entry_aged_o    = entry_aged_q;
  assign wr_ack_o        = wr_ack_q;
  assign rd_ack_o        = rd_ack_q;
  assign rd_mac_o        = rd_mac_q;
  assign rd_oq_o         = rd_oq_q;
  assign rd_wr_protect_o = rd_prot_q;
  assign rd_valid_o      = rd_valid_q;
  assign rd_age_o        = rd_age_q;

endmodule

// File: tb/tb_mac_learn_table.sv
// Bench for mac_learn_table: directed table of lookups, hand-written corner
// sequences and a randomized phase, all checked against a behavioural table model.
module tb_mac_learn_table;

  localparam int unsigned DEPTH = 32;
  localparam int AMAX = 3;
  localparam logic [7:0] MISS_PORTS = 8'h55;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] dst_mac_i = '0, src_mac_i = '0;
  logic [2:0]  src_port_i = '0;
  logic        lookup_req_i = 1'b0;
  logic [7:0]  dst_ports_o;
  logic        lookup_ack_o;
  logic        age_enable_i = 1'b0, age_tick_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_req_i = 1'b0;
  logic [47:0] rd_mac_o;
  logic [7:0]  rd_oq_o;
  logic        rd_wr_protect_o, rd_valid_o;
  logic [1:0]  rd_age_o;
  logic        rd_ack_o;
  logic [4:0]  wr_addr_i = '0;
  logic        wr_req_i = 1'b0;
  logic [47:0] wr_mac_i = '0;
  logic [7:0]  wr_oq_i = '0;
  logic        wr_protect_i = 1'b0, wr_valid_i = 1'b0;
  logic        wr_ack_o, lut_hit_o, lut_miss_o, learn_full_o, entry_aged_o;

  always #5 clk = ~clk;

  mac_learn_table #(
    .NUM_OUTPUT_QUEUES        (8),
    .NUM_IQ_BITS              (3),
    .LUT_DEPTH_BITS           (5),
    .AGE_BITS                 (2),
    .DEFAULT_MISS_OUTPUT_PORTS(8'h55)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dst_mac_i      (dst_mac_i),
    .src_mac_i      (src_mac_i),
    .src_port_i     (src_port_i),
    .lookup_req_i   (lookup_req_i),
    .dst_ports_o    (dst_ports_o),
    .lookup_ack_o   (lookup_ack_o),
    .age_enable_i   (age_enable_i),
    .age_tick_i     (age_tick_i),
    .rd_addr_i      (rd_addr_i),
    .rd_req_i       (rd_req_i),
    .rd_mac_o       (rd_mac_o),
    .rd_oq_o        (rd_oq_o),
    .rd_wr_protect_o(rd_wr_protect_o),
    .rd_valid_o     (rd_valid_o),
    .rd_age_o       (rd_age_o),
    .rd_ack_o       (rd_ack_o),
    .wr_addr_i      (wr_addr_i),
    .wr_req_i       (wr_req_i),
    .wr_mac_i       (wr_mac_i),
    .wr_oq_i        (wr_oq_i),
    .wr_protect_i   (wr_protect_i),
    .wr_valid_i     (wr_valid_i),
    .wr_ack_o       (wr_ack_o),
    .lut_hit_o      (lut_hit_o),
    .lut_miss_o     (lut_miss_o),
    .learn_full_o   (learn_full_o),
    .entry_aged_o   (entry_aged_o)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit age_en = 1'b0;

  // Behavioural model of the table contents
  bit          m_valid [DEPTH];
  bit          m_prot  [DEPTH];
  logic [7:0]  m_oq    [DEPTH];
  logic [47:0] m_mac   [DEPTH];
  int          m_agev  [DEPTH];

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [2:0]  port;
    logic [7:0]  exp_ports;
    bit          exp_hit;
  } vec_t;
  vec_t vt [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_prot[i] = 0; m_oq[i] = '0; m_mac[i] = '0; m_agev[i] = 0;
    end
    m_valid[DEPTH-1] = 1; m_prot[DEPTH-1] = 1;
    m_oq[DEPTH-1] = MISS_PORTS; m_mac[DEPTH-1] = 48'hffff_ffff_ffff;
  endfunction

  function automatic int m_find(input logic [47:0] mac);
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_mac[i] == mac) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit m_age();
    bit any = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && !m_prot[i]) begin
        if (m_agev[i] == AMAX) begin
          m_valid[i] = 0;
          any = 1;
        end else begin
          m_agev[i]++;
        end
      end
    end
    return any;
  endfunction

  // Learn decision uses the table as it stood before any tick in the same cycle.
  task automatic m_learn(input logic [47:0] src, input logic [2:0] port, input bit tk,
                         output bit full, output bit aged);
    int h = m_find(src);
    int f = m_free();
    logic [7:0] dec = 8'd1 << port;
    full = 0;
    aged = 0;
    if (tk && age_en) aged = m_age();
    if (h >= 0) begin
      if (!m_prot[h]) begin
        m_valid[h] = 1; m_oq[h] = dec; m_agev[h] = 0;
      end
    end else if (f >= 0) begin
      m_valid[f] = 1; m_prot[f] = 0; m_oq[f] = dec; m_mac[f] = src; m_agev[f] = 0;
    end else begin
      full = 1;
    end
  endtask

  task automatic set_age(input bit en);
    age_en = en;
    age_enable_i = en;
  endtask

  task automatic do_lookup(input logic [47:0] dst, input logic [47:0] src,
                           input logic [2:0] port, input bit tk,
                           output logic [7:0] got_ports, output bit got_hit);
    int d = m_find(dst);
    logic [7:0] dec = 8'd1 << port;
    logic [7:0] exp_ports = ((d >= 0) ? m_oq[d] : MISS_PORTS) & ~dec;
    bit exp_full, exp_aged;
    int lat = 0;
    dst_mac_i = dst; src_mac_i = src; src_port_i = port; lookup_req_i = 1;
    while (!lookup_ack_o && lat < 10) begin
      tick();
      lat++;
    end
    got_ports = dst_ports_o;
    got_hit = lut_hit_o;
    chk("lookup_latency", 64'(lat), 64'd2);
    chk("dst_ports", dst_ports_o, exp_ports);
    chk("lut_hit", lut_hit_o, d >= 0);
    chk("lut_miss", lut_miss_o, d < 0);
    tick();
    chk("ack_held", lookup_ack_o, 1);
    chk("ports_held", dst_ports_o, exp_ports);
    chk("hit_miss_one_cycle", {lut_hit_o, lut_miss_o}, 0);
    // This cycle is LEARN: drop the request and optionally tick aging.
    lookup_req_i = 0;
    age_tick_i = tk;
    m_learn(src, port, tk, exp_full, exp_aged);
    tick();
    age_tick_i = 0;
    chk("ack_drop", lookup_ack_o, 0);
    chk("learn_full", learn_full_o, exp_full);
    chk("entry_aged_learn", entry_aged_o, exp_aged);
  endtask

  task automatic host_write(input int a, input logic [47:0] mac, input logic [7:0] oq,
                            input bit prot, input bit val);
    wr_addr_i = 5'(a); wr_mac_i = mac; wr_oq_i = oq; wr_protect_i = prot; wr_valid_i = val;
    wr_req_i = 1;
    tick();
    wr_req_i = 0;
    chk("wr_ack", wr_ack_o, 1);
    m_valid[a] = val; m_prot[a] = prot; m_oq[a] = oq; m_mac[a] = mac; m_agev[a] = 0;
  endtask

  task automatic chk_entry(input int a);
    rd_addr_i = 5'(a);
    rd_req_i = 1;
    tick();
    rd_req_i = 0;
    chk($sformatf("rd_ack[%0d]", a), rd_ack_o, 1);
    chk($sformatf("rd_valid[%0d]", a), rd_valid_o, m_valid[a]);
    if (m_valid[a]) begin
      chk($sformatf("rd_mac[%0d]", a), rd_mac_o, m_mac[a]);
      chk($sformatf("rd_oq[%0d]", a), rd_oq_o, m_oq[a]);
      chk($sformatf("rd_protect[%0d]", a), rd_wr_protect_o, m_prot[a]);
      chk($sformatf("rd_age[%0d]", a), rd_age_o, 64'(m_agev[a]));
    end
  endtask

  task automatic age_pulse();
    bit exp = 0;
    age_tick_i = 1;
    if (age_en) exp = m_age();
    tick();
    age_tick_i = 0;
    chk("entry_aged", entry_aged_o, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] gp;
    bit gh;
    int lat;

    vt[0] = '{48'h0011_2233_4455, 48'h0a0b_0c0d_0e0f, 3'd2, 8'h51, 1'b0};
    vt[1] = '{48'h0a0b_0c0d_0e0f, 48'h1111_1111_1111, 3'd0, 8'h04, 1'b1};
    vt[2] = '{48'h1111_1111_1111, 48'h0a0b_0c0d_0e0f, 3'd4, 8'h01, 1'b1};
    vt[3] = '{48'h0a0b_0c0d_0e0f, 48'h1111_1111_1111, 3'd1, 8'h10, 1'b1};
    vt[4] = '{48'hffff_ffff_ffff, 48'h2222_2222_2222, 3'd0, 8'h54, 1'b1};

    // Reset values; requests during INIT are ignored.
    tick();
    tick();
    chk("reset_dst_ports", dst_ports_o, 0);
    chk("reset_outputs", {lookup_ack_o, rd_ack_o, wr_ack_o, lut_hit_o, lut_miss_o,
                          learn_full_o, entry_aged_o, rd_valid_o}, 0);
    reset = 0;
    wr_addr_i = 5'd3; wr_mac_i = 48'hdead_beef_0003; wr_oq_i = 8'h08; wr_valid_i = 1;
    dst_mac_i = 48'h1234; src_mac_i = 48'h5678;
    for (int c = 0; c < int'(DEPTH) + 2; c++) begin
      wr_req_i = (c >= 4 && c < 8);
      rd_req_i = (c >= 4 && c < 8);
      lookup_req_i = (c >= 4 && c < 8);
      tick();
      chk("init_quiet", {wr_ack_o, rd_ack_o, lookup_ack_o}, 0);
    end
    m_reset();
    for (int i = 0; i < int'(DEPTH); i++) chk_entry(i);

    // Directed lookups and learning
    for (int i = 0; i < 5; i++) begin
      do_lookup(vt[i].dst, vt[i].src, vt[i].port, 0, gp, gh);
      chk($sformatf("vec%0d_ports", i), gp, vt[i].exp_ports);
      chk($sformatf("vec%0d_hit", i), gh, vt[i].exp_hit);
    end
    chk_entry(0);
    chk("entry0_oq_relearned", rd_oq_o, 8'h10);
    chk_entry(1);
    chk_entry(2);

    // Aging up to AGE_MAX
    set_age(1);
    repeat (3) age_pulse();
    chk_entry(0);
    chk("entry0_age_max", rd_age_o, 2'd3);
    chk_entry(DEPTH - 1);

    // Learn refresh wins over expiry in the same cycle
    do_lookup(48'h0a0b_0c0d_0e0f, 48'h0a0b_0c0d_0e0f, 3'd3, 1, gp, gh);
    chk_entry(0);
    chk("entry0_refreshed_valid", rd_valid_o, 1);
    chk_entry(1);
    chk_entry(2);

    // Expiry on the fourth tick; broadcast entry survives
    repeat (3) age_pulse();
    chk_entry(0);
    age_pulse();
    chk_entry(0);
    chk("entry0_expired", rd_valid_o, 0);
    chk_entry(DEPTH - 1);
    set_age(0);

    // Write and lookup requested together: write first
    wr_addr_i = 5'd5; wr_mac_i = 48'habcd_0000_0005; wr_oq_i = 8'h20;
    wr_protect_i = 0; wr_valid_i = 1; wr_req_i = 1;
    dst_mac_i = 48'habcd_0000_0005; src_mac_i = 48'h3333_3333_3333; src_port_i = 3'd1;
    lookup_req_i = 1;
    tick();
    wr_req_i = 0;
    chk("combo_wr_ack", wr_ack_o, 1);
    chk("combo_ack_early0", lookup_ack_o, 0);
    m_valid[5] = 1; m_prot[5] = 0; m_oq[5] = 8'h20; m_mac[5] = 48'habcd_0000_0005; m_agev[5] = 0;
    tick();
    chk("combo_ack_early1", lookup_ack_o, 0);
    tick();
    chk("combo_ack", lookup_ack_o, 1);
    chk("combo_ports", dst_ports_o, 8'h20);
    chk("combo_hit", lut_hit_o, 1);
    lookup_req_i = 0;
    begin
      bit ef, ea;
      m_learn(48'h3333_3333_3333, 3'd1, 0, ef, ea);
    end
    tick();
    tick();
    chk_entry(0);

    // Fill every free slot, then a new source cannot be learned
    for (int i = 0; i < int'(DEPTH) - 1; i++) host_write(i, 48'h0000_5a00_0000 + 48'(i), 8'(i + 1), 0, 1);
    do_lookup(48'h0000_5a00_0003, 48'h4444_4444_4444, 3'd6, 0, gp, gh);
    chk("full_ports", gp, 8'h04);
    for (int i = 0; i < int'(DEPTH); i++) chk_entry(i);

    // Reset while a lookup is acknowledged
    dst_mac_i = 48'h0000_5a00_0001; src_mac_i = 48'h0000_5a00_0002; lookup_req_i = 1;
    lat = 0;
    while (!lookup_ack_o && lat < 10) begin
      tick();
      lat++;
    end
    chk("pre_reset_ack", lookup_ack_o, 1);
    reset = 1;
    tick();
    chk("midreset_ack_drop", lookup_ack_o, 0);
    chk("midreset_ports", dst_ports_o, 0);
    reset = 0;
    lookup_req_i = 0;
    repeat (DEPTH + 2) tick();
    m_reset();
    chk_entry(0);
    chk_entry(5);
    chk_entry(DEPTH - 1);

    // Randomized operations against the model
    set_age(1);
    for (int n = 0; n < 150; n++) begin
      int r = $urandom_range(0, 9);
      logic [47:0] pool_a = 48'h0200_0000_0000 + 48'($urandom_range(0, 9));
      logic [47:0] pool_b = 48'h0200_0000_0000 + 48'($urandom_range(0, 9));
      if (r <= 4) begin
        if ($urandom_range(0, 7) == 0) pool_a = 48'hffff_ffff_ffff;
        do_lookup(pool_a, pool_b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), gp, gh);
      end else if (r <= 6) begin
        host_write($urandom_range(0, DEPTH - 1), pool_a, 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end else if (r == 7) begin
        chk_entry($urandom_range(0, DEPTH - 1));
      end else begin
        age_pulse();
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) chk_entry(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
